// File: rtl/i2s_tdm_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_tdm_tx_if                                                            |
// | Frame handshake between the sample FIFO (master) and the transmitter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface i2s_tdm_tx_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32
) ();
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/i2s_tdm_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_tdm_tx                                                               |
// | I2S / justified / TDM serial-audio transmitter, one frame held in front  |
// | of the serialiser. Define I2S_TX_UNDERRUN_REPEAT_EN to repeat the last   |
// | frame on underrun instead of sending zeros.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2s_tdm_tx #(
  parameter int NUM_CH = 2,
  parameter int SLOT_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck_tick,
  input  logic [1:0]  standard,
  input  logic [1:0]  word_size,
  input  logic        stop,
  input  logic        mute,
  i2s_tdm_tx_if.slave s_in,
  output logic        sd,
  output logic        ws,
  output logic        frame_start,
  output logic        underrun,
  output logic        busy
);

  localparam int c_FRAME_W = NUM_CH * DATA_W;
  localparam int c_SLOT_BW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_BIT_BW  = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int c_IDX_BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [c_SLOT_BW-1:0] c_LAST_SLOT = c_SLOT_BW'(NUM_CH - 1);
  localparam logic [c_BIT_BW-1:0]  c_LAST_BIT  = c_BIT_BW'(SLOT_W - 1);
  localparam logic [7:0]           c_SLOT_W8   = 8'(SLOT_W);
  localparam logic [7:0]           c_DATA_W8   = 8'(DATA_W);
  localparam logic                 c_STEREO    = (NUM_CH == 2);

  localparam logic [1:0] c_STD_LSB = 2'b10;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LEAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;

  logic [1:0]           r_state;
  logic [c_SLOT_BW-1:0] r_slot;
  logic [c_BIT_BW-1:0]  r_bit;
  logic [c_FRAME_W-1:0] r_frame;
  logic [c_FRAME_W-1:0] r_hold;
  logic                 r_hold_empty;
  logic [1:0]           r_std;
  logic [7:0]           r_wlen;
  logic                 r_sd;
  logic                 r_ws;
  logic                 r_fstart;
  logic                 r_urun;
  logic                 r_busy;

  logic [1:0]           w_state_nxt;
  logic [c_SLOT_BW-1:0] w_slot_nxt;
  logic [c_BIT_BW-1:0]  w_bit_nxt;
  logic [c_FRAME_W-1:0] w_frame_nxt;
  logic [c_FRAME_W-1:0] w_underrun_frame;
  logic [1:0]           w_std_nxt;
  logic [7:0]           w_wlen_nxt;
  logic                 w_start;
  logic                 w_load;
  logic                 w_urun;
  logic                 w_boundary;

  logic [DATA_W-1:0]    w_lane;
  logic [7:0]           w_bit8;
  logic                 w_in_word;
  logic [c_IDX_BW-1:0]  w_idx;
  logic                 w_data_bit;
  logic                 w_i2s;
  logic                 w_ws_run;
  logic                 w_sd_nxt;
  logic                 w_ws_nxt;

  function automatic logic is_i2s(input logic [1:0] std);
    return (std == 2'b00) || (std == 2'b11);
  endfunction

  // Effective word length: requested size clipped to slot and lane widths.
  function automatic logic [7:0] eff_wlen(input logic [1:0] wsz);
    logic [7:0] len;
    case (wsz)
      2'b00:   len = 8'd16;
      2'b01:   len = 8'd24;
      default: len = 8'd32;
    endcase
    if (len > c_SLOT_W8) len = c_SLOT_W8;
    if (len > c_DATA_W8) len = c_DATA_W8;
    return len;
  endfunction

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  // r_frame only changes on a load, so it already holds the last loaded frame.
  assign w_underrun_frame = r_frame;
`else
  assign w_underrun_frame = '0;
`endif

  assign w_boundary = (r_slot == c_LAST_SLOT) && (r_bit == c_LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else if (sck_tick) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_bit_nxt   = r_bit;
    w_frame_nxt = r_frame;
    w_std_nxt   = r_std;
    w_wlen_nxt  = r_wlen;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_urun      = 1'b0;
    if (sck_tick) begin
      case (r_state)
        c_IDLE: begin
          if (!stop && !r_hold_empty) begin
            if (is_i2s(standard)) begin
              w_state_nxt = c_LEAD;
            end else begin
              w_state_nxt = c_RUN;
              w_start     = 1'b1;
            end
          end
        end
        c_LEAD: begin
          w_state_nxt = c_RUN;
          w_start     = 1'b1;
        end
        c_RUN: begin
          if (w_boundary) begin
            if (stop) begin
              w_state_nxt = c_IDLE;
              w_slot_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              w_start = 1'b1;
            end
          end else if (r_bit == c_LAST_BIT) begin
            w_bit_nxt  = '0;
            w_slot_nxt = r_slot + 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end
    // Frame start: framing parameters are frozen for the whole frame.
    if (w_start) begin
      w_slot_nxt = '0;
      w_bit_nxt  = '0;
      w_std_nxt  = standard;
      w_wlen_nxt = eff_wlen(word_size);
      if (!r_hold_empty) begin
        w_frame_nxt = r_hold;
        w_load      = 1'b1;
      end else begin
        w_frame_nxt = w_underrun_frame;
        w_urun      = 1'b1;
      end
    end
  end

  always_comb begin
    w_lane = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_slot_nxt == c_SLOT_BW'(c)) w_lane = w_frame_nxt[c*DATA_W +: DATA_W];
    end
    w_bit8 = 8'(w_bit_nxt);
    if (w_std_nxt == c_STD_LSB) begin
      w_in_word = (w_bit8 >= (c_SLOT_W8 - w_wlen_nxt));
      w_idx     = c_IDX_BW'(c_SLOT_W8 - 8'd1 - w_bit8);
    end else begin
      w_in_word = (w_bit8 < w_wlen_nxt);
      w_idx     = c_IDX_BW'(w_wlen_nxt - 8'd1 - w_bit8);
    end
    w_data_bit = w_in_word && w_lane[w_idx];

    w_i2s = is_i2s(w_std_nxt);
    if (c_STEREO) begin
      // I2S moves ws one bit ahead of the slot it announces.
      if (w_i2s) begin
        w_ws_run = (w_slot_nxt == '0) ? (w_bit_nxt == c_LAST_BIT) : (w_bit_nxt != c_LAST_BIT);
      end else begin
        w_ws_run = (w_slot_nxt != '0);
      end
    end else begin
      if (w_i2s) begin
        w_ws_run = (w_slot_nxt == c_LAST_SLOT) && (w_bit_nxt == c_LAST_BIT);
      end else begin
        w_ws_run = (w_slot_nxt == '0) && (w_bit_nxt == '0);
      end
    end

    case (w_state_nxt)
      c_LEAD: begin
        w_sd_nxt = 1'b0;
        w_ws_nxt = !c_STEREO;
      end
      c_RUN: begin
        w_sd_nxt = w_data_bit && !mute;
        w_ws_nxt = w_ws_run;
      end
      default: begin
        w_sd_nxt = 1'b0;
        w_ws_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot   <= '0;
      r_bit    <= '0;
      r_frame  <= '0;
      r_std    <= 2'b00;
      r_wlen   <= 8'd0;
      r_sd     <= 1'b0;
      r_ws     <= 1'b0;
      r_fstart <= 1'b0;
      r_urun   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_fstart <= w_start;
      r_urun   <= w_urun;
      if (sck_tick) begin
        r_slot  <= w_slot_nxt;
        r_bit   <= w_bit_nxt;
        r_frame <= w_frame_nxt;
        r_std   <= w_std_nxt;
        r_wlen  <= w_wlen_nxt;
        r_sd    <= w_sd_nxt;
        r_ws    <= w_ws_nxt;
        r_busy  <= (w_state_nxt != c_IDLE);
      end
    end
  end

  // Capture and load are mutually exclusive: capture needs the buffer empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold       <= '0;
      r_hold_empty <= 1'b1;
    end else if (s_in.in_valid && r_hold_empty) begin
      r_hold       <= s_in.in_data;
      r_hold_empty <= 1'b0;
    end else if (w_load) begin
      r_hold_empty <= 1'b1;
    end
  end

  assign s_in.in_ready = r_hold_empty;
  assign sd            = r_sd;
  assign ws            = r_ws;
  assign frame_start   = r_fstart;
  assign underrun      = r_urun;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised serial-audio transmitter. It generalises the fixed stereo/mono I2S transmit path to NUM_CH slots per frame (2 = classic I2S/justified, >2 = TDM). Serialises frames from a single-entry holding buffer onto sd/ws, advancing on an external bit-clock tick from the clock-generation block. Sits between the sample FIFO (valid/ready) and the pad-level sck/ws/sd logic.

Parameters:
NUM_CH, 2, slots per frame (>=2); 2 = stereo I2S/MSB/LSB framing, >2 = TDM framing
SLOT_W, 32, bits per slot (16 or 32)
DATA_W, 32, width of each channel lane in in_data; sample right-aligned in lane

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sck_tick  in  1  one-clk pulse per bit period (bit-clock falling edge equivalent)
standard  in  2  00 I2S, 01 MSB-justified, 10 LSB-justified, 11 treated as I2S
word_size  in  2  00 16b, 01 24b, 10 32b, 11 treated as 32b
stop  in  1  finish current frame then idle
mute  in  1  force sd=0, framing and consumption continue
in_data  in  NUM_CH*DATA_W  frame, channel 0 in LSB lane
in_valid  in  1  in_data valid
in_ready  out  1  holding buffer empty
sd  out  1  serial data
ws  out  1  word select / frame sync
frame_start  out  1  one-clk pulse when slot 0 bit 0 is driven
underrun  out  1  one-clk pulse when frame boundary finds buffer empty
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate, including mid-frame): sd=0, ws=0, frame_start=0, underrun=0, busy=0, in_ready=1, hold empty, state IDLE, counters 0.
- Handshake: in_valid&&in_ready captures in_data into hold; in_ready=0 next cycle. Hold is freed (in_ready=1 next cycle) when moved to shift register. in_valid held without ready: no effect.
- All outputs registered; state/sd/ws change only on clk edges where sck_tick=1 (except handshake signals, which update on any clk).
- States: IDLE -> (tick, !stop, hold full) -> LEAD if standard=I2S else RUN. LEAD lasts one tick: sd=0, ws=0 if NUM_CH=2 else ws=1. LEAD -> RUN on the next tick.
- Entering RUN, or passing a frame boundary (tick at slot NUM_CH-1, bit SLOT_W-1): load shift reg from hold; sample standard/word_size; slot=0, bit=0; frame_start pulse. If hold empty at boundary: frame is zeros, underrun pulse, stays RUN. If stop=1 at boundary: -> IDLE, sd=0, ws=0, hold untouched.
- Counters: bit 0..SLOT_W-1 wraps to 0 and increments slot; slot wraps 0..NUM_CH-1.
- Effective word W = min(word_size bits, SLOT_W, DATA_W); MSBs beyond W dropped. I2S/MSB: MSB of W at bit 0, bits >= W are 0. LSB: word occupies bits SLOT_W-W..SLOT_W-1, MSB first, leading bits 0.
- ws, NUM_CH=2: 0 during slot 0, 1 during slot 1; MSB/LSB change at bit 0 of slot, I2S change one tick early (bit SLOT_W-1 of preceding slot).
- ws, NUM_CH>2: one-tick pulse; MSB/LSB at slot 0 bit 0; I2S at last bit of last slot (and in LEAD).
- mute: sd=0; ws, frame_start, handshake unchanged.
- stop asserted then released before boundary: no effect.

Optional Feature:
I2S_TX_UNDERRUN_REPEAT_EN: defined -> on underrun the previous frame is retransmitted (last loaded frame kept in a shadow register); underrun still pulses; zeros if no frame loaded since reset. Undefined -> underrun frame is all zeros, no shadow register.

Test Plan:
- NUM_CH=2, SLOT_W=32, MSB, 16b, in_data={16'hA5A5 ch1, 16'h1234 ch0} -> sd = 0x1234 MSB-first then 16 zeros, ws 0 for 32 ticks then 1 for 32; frame_start at first bit.
- Same frame, I2S -> one LEAD tick (sd=0, ws=0), ws rises at tick 31 of slot 0, falls at tick 31 of slot 1; data aligned as MSB.
- LSB, 24b, ch0=24'hABCDEF, SLOT_W=32 -> 8 zeros then 0xABCDEF MSB-first in slot 0.
- NUM_CH=4, MSB -> ws one-tick pulse every 128 ticks coincident with frame_start; channels 0..3 in order.
- No second frame supplied -> underrun pulse at boundary, 64 zero bits (or repeated frame with I2S_TX_UNDERRUN_REPEAT_EN); stop mid-frame -> frame completes, busy falls at boundary.
- rst asserted at slot 1 bit 10 -> sd=ws=0, busy=0, in_ready=1 immediately; mute=1 -> sd stays 0 while ws toggles normally.
